sha256_msg_schedule: RTL and testbench



---
 rtl/sha256_msg_schedule.sv | 86 ++++++++
 tb/tb_sha256_msg_schedule.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W0..W63 using a
// 16-word sliding window, advancing one word per step_i.
module sha256_msg_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [511:0] block_i,
  input  logic         step_i,
  output logic [31:0]  w_o,
  output logic [5:0]   t_o,
  output logic         valid_o,
  output logic         done_o
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic        done_q, done_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] w_new;
  logic [511:0] blk;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    done_d  = 1'b0;
    win_d   = win_q;
    blk     = block_i;
    w_new   = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    if (load_i) begin
      // M0 sits in the top word; peel words off the top while shifting left
      for (int unsigned k = 0; k < 16; k++) begin
        win_d[k] = blk[511:480];
        blk      = blk << 32;
      end
      t_d     = '0;
      state_d = RUN;
    end else if (state_q == RUN && step_i) begin
      if (t_q == 6'd63) begin
        state_d = IDLE;
        t_d     = '0;
        done_d  = 1'b1;
      end else begin
        for (int unsigned k = 0; k < 15; k++) begin
          win_d[k] = win_q[k+1];
        end
        win_d[15] = w_new;
        t_d       = t_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
      for (int unsigned k = 0; k < 16; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      for (int unsigned k = 0; k < 16; k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

  assign w_o     = win_q[0];
  assign t_o     = t_q;
  assign valid_o = (state_q == RUN);
  assign done_o  = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: expected words come from a software
// schedule model and are queued at load time, popped as each word is consumed.
module tb_sha256_msg_schedule;

  logic         clk;
  logic         rst_n;
  logic         load_i;
  logic [511:0] block_i;
  logic         step_i;
  logic [31:0]  w_o;
  logic [5:0]   t_o;
  logic         valid_o;
  logic         done_o;

  sha256_msg_schedule dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_i),
    .block_i (block_i),
    .step_i  (step_i),
    .w_o     (w_o),
    .t_o     (t_o),
    .valid_o (valid_o),
    .done_o  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  t;
    logic [31:0] w;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_w [64];
  logic [31:0] cap_w [64];
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam logic [511:0] ABC_BLOCK = {32'h61626380, {14{32'h0}}, 32'h00000018};

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block(input logic [511:0] b);
    logic [511:0] tmp;
    exp_t e;
    tmp = b;
    for (int k = 0; k < 16; k++) begin
      ref_w[k] = tmp[511:480];
      tmp = tmp << 32;
    end
    for (int k = 16; k < 64; k++) begin
      ref_w[k] = m_s1(ref_w[k-2]) + ref_w[k-7] + m_s0(ref_w[k-15]) + ref_w[k-16];
    end
    sb.delete();
    for (int k = 0; k < 64; k++) begin
      e.t = 6'(k);
      e.w = ref_w[k];
      sb.push_back(e);
    end
  endtask

  task automatic load_block(input logic [511:0] b, input logic st);
    push_block(b);
    load_i  = 1'b1;
    block_i = b;
    step_i  = st;
    tick();
    load_i = 1'b0;
    step_i = 1'b0;
    check("load_t", 32'(t_o), 32'd0);
    check("load_w", w_o, b[511:480]);
    check("load_valid", 32'(valid_o), 32'd1);
    check("load_done", 32'(done_o), 32'd0);
  endtask

  task automatic run_steps(input int n, input bit gapped);
    int   consumed;
    int   budget;
    logic st;
    exp_t e;
    consumed = 0;
    budget   = 0;
    while (consumed < n && budget < 2000) begin
      budget++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL sb_underflow: got empty queue expected pending word");
        break;
      end
      e  = sb[0];
      st = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      check("run_valid", 32'(valid_o), 32'd1);
      check("run_w", w_o, e.w);
      check("run_t", 32'(t_o), 32'(e.t));
      check("run_done_low", 32'(done_o), 32'd0);
      load_i = 1'b0;
      step_i = st;
      if (st) begin
        cap_w[e.t] = w_o;
        void'(sb.pop_front());
        consumed++;
      end
      tick();
    end
    step_i = 1'b0;
    if (consumed < n) begin
      n_tests++;
      n_fail++;
      $error("FAIL run_budget: got %0d words expected %0d", consumed, n);
    end
  endtask

  task automatic check_done_pulse(input string tag);
    check({tag, "_done_hi"}, 32'(done_o), 32'd1);
    check({tag, "_valid_lo"}, 32'(valid_o), 32'd0);
    check({tag, "_t_zero"}, 32'(t_o), 32'd0);
    tick();
    check({tag, "_done_lo"}, 32'(done_o), 32'd0);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    b = '0;
    for (int k = 0; k < 16; k++) begin
      b = {b[479:0], 32'($urandom())};
    end
    return b;
  endfunction

  initial begin
    logic [511:0] blk_a;
    logic [511:0] blk_b;
    logic [511:0] blk_c;

    rst_n   = 1'b0;
    load_i  = 1'b0;
    step_i  = 1'b0;
    block_i = '0;
    tick();
    tick();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_t", 32'(t_o), 32'd0);
    check("rst_w", w_o, 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // abc block with step_i held high
    load_block(ABC_BLOCK, 1'b0);
    run_steps(64, 1'b0);
    check_done_pulse("abc");
    check("abc_w0", cap_w[0], 32'h61626380);
    check("abc_w15", cap_w[15], 32'h00000018);
    check("abc_w16", cap_w[16], 32'h61626380);
    check("abc_w17", cap_w[17], 32'h000F0000);

    // gapped stepping, same block
    load_block(ABC_BLOCK, 1'b0);
    run_steps(64, 1'b1);
    check_done_pulse("gap");

    // abort mid-schedule with step_i high alongside the new load
    blk_a = rand_block();
    blk_b = rand_block();
    load_block(blk_a, 1'b0);
    run_steps(30, 1'b0);
    check("abort_pre_t", 32'(t_o), 32'd30);
    load_block(blk_b, 1'b1);
    run_steps(64, 1'b0);
    check_done_pulse("abort");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_2nd_done", 32'(done_o), 32'd0);
    end

    // back-to-back: load lands on the W63 step
    blk_c = rand_block();
    load_block(ABC_BLOCK, 1'b0);
    run_steps(63, 1'b0);
    check("b2b_pre_t", 32'(t_o), 32'd63);
    load_block(blk_c, 1'b1);
    run_steps(64, 1'b0);
    check_done_pulse("b2b");

    // asynchronous reset mid-run at t=20
    load_block(ABC_BLOCK, 1'b0);
    run_steps(20, 1'b0);
    check("arst_pre_t", 32'(t_o), 32'd20);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_t", 32'(t_o), 32'd0);
    check("arst_w", w_o, 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    tick();
    rst_n  = 1'b1;
    step_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_valid", 32'(valid_o), 32'd0);
      check("idle_t", 32'(t_o), 32'd0);
      check("idle_done", 32'(done_o), 32'd0);
      check("idle_w", w_o, 32'd0);
    end
    step_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
